poly_pack_stream: RTL and testbench
===================================

// Module: poly_pack_stream
// PURPOSE
//  Streaming, parametrised successor of the single-shot Kyber byte packer.
//  - Accepts N signed polynomial coefficients one per handshake.
//  - Maps each into [0,Q) with a conditional add of Q.
//  - Keeps the low d bits, d selectable per run (1..D_MAX), e.g. 12 (tobytes), 10/11/4/5 (compress).
//  - Emits the little-endian bit-packed byte stream through a valid/ready port.
//  - Sits between the ATHOS coefficient datapath and the memory/bus writer.
// PARAMETERS
//  N      256   coefficients per run
//  Q      3329  modulus added to negative inputs
//  D_MAX  12    max bits per coefficient; accumulator width ACC_W = D_MAX+7
// PORTS
//  clk_i          in   1              clock, rising edge
//  rst_ni         in   1              async active-low reset
//  start_i        in   1              begin run (sampled in IDLE only)
//  d_i            in   4              bits/coeff, latched on start; 0 or >D_MAX -> D_MAX
//  coeff_valid_i  in   1              coefficient present
//  coeff_ready_o  out  1              coefficient accepted when valid&ready
//  coeff_i        in   16             signed coefficient, range (-Q,Q)
//  byte_valid_o   out  1              packed byte present
//  byte_ready_i   in   1              sink accepts byte
//  byte_o         out  8              packed byte
//  busy_o         out  1              run in progress (state != IDLE)
//  done_o         out  1              1-cycle pulse after last byte handshake
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; acc=0; fill=0; cnt=0; d_q=D_MAX.
//    All outputs read 0.
//  - Map: t = coeff_i + (coeff_i[15] ? Q : 0) (16-bit); v = t & ((1<<d_q)-1).
//  - Accumulator: on accept, acc |= v << fill; fill += d_q; cnt++.
//    On byte handshake, acc >>= 8; fill -= 8.
//  - byte_o = acc[7:0] (registered state, no comb path from inputs).
//  - FSM:
//    - IDLE: start_i -> PACK; latch d_q; clear acc, fill, cnt.
//      coeff_ready_o=0, byte_valid_o=0.
//    - PACK:
//      - coeff_ready_o = (fill<8) && (cnt<N).
//      - byte_valid_o = (fill>=8).
//      - The two are mutually exclusive, so there is no simultaneous accept and pop.
//      - When cnt==N && fill<8: -> FLUSH.
//    - FLUSH: if fill>0, byte_valid_o=1 with byte_o = acc[7:0], upper bits zero-padded.
//      On handshake fill=0.
//      When fill==0 -> DONE.
//    - DONE: done_o=1 for exactly one cycle -> IDLE.
//  - Total bytes per run = ceil(N*d_q/8). The first byte is valid 1 cycle after the accepting edge.
//  - Handshake rules:
//    - byte_valid_o and byte_o hold stable until byte_ready_i.
//    - coeff_i is ignored unless valid&ready.
//    - coeff_valid_i may drop freely.
//  - Width: fill never exceeds 7+D_MAX = ACC_W. cnt is $clog2(N+1) bits and saturates at N.
//  - start_i while busy_o=1 is ignored. d_i changes mid-run have no effect.
//  - Reset mid-run aborts it: no done_o, partial bytes are discarded.
// TESTING
//  1. N=2, d=12, coeffs 0x001,0x002 -> bytes 0x01,0x20,0x00, then done_o pulse; busy_o low after.
//  2. N=2, d=12, coeffs 0xFFFF(-1),0x0000 -> t=0xD00 -> bytes 0x00,0x0D,0x00.
//  3. N=3, d=4, coeffs 0xA,0xB,0xC -> bytes 0xBA, 0x0C (zero-padded flush) -> done_o;
//     d_i=0 run behaves as d=12.
//  4. N=256, d=12, coeff_valid_i always 1, byte_ready_i low 5 cycles at byte 7 ->
//     byte_o/byte_valid_o stable, no coeff accepted while fill>=8; 384 bytes total, matching the reference model.
//  5. N=256, d=10 and d=4 random coeffs in (-Q,Q) with random valid/ready gaps ->
//     320 / 128 bytes equal to the model; start_i pulses mid-run ignored.
//  6. rst_ni low mid-PACK (cnt=100) -> all outputs 0 immediately, no done_o.
//     A new start then yields a full correct run.

Source files
------------

// File: rtl/poly_pack_stream.sv
// Maps signed coefficients into [0,Q), keeps d_q low bits and bit-packs them little-endian into bytes.
// Latency: first byte valid one cycle after the accepting edge; byte_o is registered (no input comb path).
// Backpressure: coeff_ready_o drops while a full byte waits or after N coeffs; byte holds until byte_ready_i.
module poly_pack_stream #(
    parameter int N     = 256,
    parameter int Q     = 3329,
    parameter int D_MAX = 12
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [3:0] d_i,
    input  logic       coeff_valid_i,
    output logic       coeff_ready_o,
    input  logic [15:0] coeff_i,
    output logic       byte_valid_o,
    input  logic       byte_ready_i,
    output logic [7:0] byte_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int ACC_W  = D_MAX + 7;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int CNT_W  = $clog2(N + 1);

    localparam logic [CNT_W-1:0]  N_C    = CNT_W'(N);
    localparam logic [15:0]       Q_C    = 16'(Q);
    localparam logic [3:0]        DMAX_C = 4'(D_MAX);
    localparam logic [FILL_W-1:0] EIGHT  = FILL_W'(8);
    localparam logic [FILL_W-1:0] ZERO_F = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PACK,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [ACC_W-1:0]   acc;
    logic [FILL_W-1:0]  fill;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         d_q;

    logic [15:0]        t_map;
    logic [15:0]        mask;
    logic [15:0]        v;
    logic [ACC_W-1:0]   v_sh;
    logic               accept;
    logic               pop;

    // Accepts only happen with fill<8, so v<<fill never spills past ACC_W.
    always_comb begin
        t_map = coeff_i + (coeff_i[15] ? Q_C : 16'd0);
        mask  = (16'd1 << d_q) - 16'd1;
        v     = t_map & mask;
        v_sh  = ACC_W'(v) << fill;
    end

    always_comb begin
        state_nx      = state;
        coeff_ready_o = 1'b0;
        byte_valid_o  = 1'b0;
        done_o        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) state_nx = S_PACK;
            end
            S_PACK: begin
                coeff_ready_o = (fill < EIGHT) && (cnt < N_C);
                byte_valid_o  = (fill >= EIGHT);
                if ((cnt == N_C) && (fill < EIGHT)) state_nx = S_FLUSH;
            end
            S_FLUSH: begin
                byte_valid_o = (fill != ZERO_F);
                if (fill == ZERO_F) state_nx = S_DONE;
            end
            S_DONE: begin
                done_o   = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign accept = coeff_valid_i & coeff_ready_o;
    assign pop    = byte_valid_o & byte_ready_i;
    assign busy_o = (state != S_IDLE);
    // Bits above fill are always zero, so a flushed partial byte is zero-padded.
    assign byte_o = acc[7:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
            acc   <= '0;
            fill  <= '0;
            cnt   <= '0;
            d_q   <= DMAX_C;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        d_q  <= ((d_i == 4'd0) || (d_i > DMAX_C)) ? DMAX_C : d_i;
                        acc  <= '0;
                        fill <= '0;
                        cnt  <= '0;
                    end
                end
                S_PACK: begin
                    if (accept) begin
                        acc  <= acc | v_sh;
                        fill <= fill + FILL_W'(d_q);
                        cnt  <= cnt + CNT_W'(1);
                    end else if (pop) begin
                        acc  <= acc >> 8;
                        fill <= fill - EIGHT;
                    end
                end
                S_FLUSH: begin
                    if (pop) begin
                        acc  <= '0;
                        fill <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_pack_stream.sv
// Directed bench for poly_pack_stream: a 3-coefficient instance for hand-computed byte vectors,
// and a 256-coefficient instance checked against a bit-serial packing model.
module tb_poly_pack_stream;

    localparam int Q = 3329;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        s_start, s_cv, s_cr, s_bv, s_br, s_busy, s_done;
    logic [3:0]  s_d;
    logic [15:0] s_coeff;
    logic [7:0]  s_byte;

    logic        b_start, b_cv, b_cr, b_bv, b_br, b_busy, b_done;
    logic [3:0]  b_d;
    logic [15:0] b_coeff;
    logic [7:0]  b_byte;

    poly_pack_stream #(.N(3), .Q(Q), .D_MAX(12)) u_small (
        .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .d_i(s_d),
        .coeff_valid_i(s_cv), .coeff_ready_o(s_cr), .coeff_i(s_coeff),
        .byte_valid_o(s_bv), .byte_ready_i(s_br), .byte_o(s_byte),
        .busy_o(s_busy), .done_o(s_done)
    );

    poly_pack_stream #(.N(256), .Q(Q), .D_MAX(12)) u_big (
        .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .d_i(b_d),
        .coeff_valid_i(b_cv), .coeff_ready_o(b_cr), .coeff_i(b_coeff),
        .byte_valid_o(b_bv), .byte_ready_i(b_br), .byte_o(b_byte),
        .busy_o(b_busy), .done_o(b_done)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] cq[$];
    logic [7:0]  eq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected stream built bit by bit: d LSBs of each mapped coefficient, LSB first, zero-padded.
    function automatic void build_model(input int d);
        bit bits[$];
        int t;
        logic [7:0] by;
        eq.delete();
        foreach (cq[i]) begin
            t = int'($signed(cq[i]));
            if (t < 0) t = t + Q;
            for (int b = 0; b < d; b++) bits.push_back(t[b]);
        end
        while ((bits.size() % 8) != 0) bits.push_back(1'b0);
        for (int k = 0; k < bits.size(); k += 8) begin
            for (int b = 0; b < 8; b++) by[b] = bits[k + b];
            eq.push_back(by);
        end
    endfunction

    task automatic run_small(input logic [3:0] d, input string tag);
        int ci, bi;
        bit done_seen;
        ci = 0; bi = 0; done_seen = 0;
        @(negedge clk);
        s_d = d; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0; s_d = 4'd7;
        chk({tag, "/busy"}, 32'(s_busy), 32'd1);
        for (int cyc = 0; cyc < 100 && !done_seen; cyc++) begin
            s_cv    = (ci < cq.size());
            s_coeff = s_cv ? cq[ci] : 16'h7FFF;
            s_br    = ((cyc % 3) != 1);
            if (s_cv && s_cr) ci++;
            if (s_bv && s_br) begin
                chk($sformatf("%s/byte%0d", tag, bi), 32'(s_byte), (bi < eq.size()) ? 32'(eq[bi]) : 32'hEE);
                bi++;
            end
            if (s_done) done_seen = 1'b1;
            @(negedge clk);
        end
        s_cv = 1'b0; s_br = 1'b0;
        chk({tag, "/done"}, 32'(done_seen), 32'd1);
        chk({tag, "/nbytes"}, 32'(bi), 32'(eq.size()));
        chk({tag, "/idle_after"}, {30'd0, s_busy, s_done}, 32'd0);
    endtask

    // mode 0: valid always high, 5-cycle ready stall at byte 7; mode 1: random gaps + stray starts.
    task automatic run_big(input logic [3:0] d_in, input int d_eff, input int mode,
                           input int abort_at, input string tag);
        int ci, bi, viol, excl, stall, r;
        bit done_seen, hold_prev;
        logic [7:0] held, prev_byte;
        ci = 0; bi = 0; viol = 0; excl = 0; stall = -1; done_seen = 0; hold_prev = 0;
        held = '0; prev_byte = '0;
        cq.delete();
        for (int i = 0; i < 256; i++) begin
            r = int'($urandom_range(0, 2 * Q - 2)) - (Q - 1);
            cq.push_back(16'(r));
        end
        build_model(d_eff);
        @(negedge clk);
        b_d = d_in; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int cyc = 0; cyc < 6000 && !done_seen; cyc++) begin
            if (hold_prev && (!b_bv || b_byte !== prev_byte)) viol++;
            if (b_bv && b_cr) excl++;
            if (mode == 0) begin
                b_cv = 1'b1;
                if (stall == -1 && bi == 7 && b_bv) begin
                    stall = 5;
                    held  = b_byte;
                end
                if (stall > 0) begin
                    b_br = 1'b0;
                    if (!b_bv || b_byte !== held || b_cr) viol++;
                    stall--;
                    if (stall == 0) stall = -2;
                end else begin
                    b_br = 1'b1;
                end
            end else begin
                b_cv    = (ci < 256) && ($urandom_range(0, 3) != 0);
                b_br    = ($urandom_range(0, 2) != 0);
                b_start = !b_done && ($urandom_range(0, 15) == 0);
                b_d     = 4'($urandom_range(1, 15));
            end
            b_coeff = (b_cv && ci < 256) ? cq[ci] : 16'hABCD;
            if (b_cv && b_cr) ci++;
            if (b_bv && b_br) begin
                chk($sformatf("%s/byte%0d", tag, bi), 32'(b_byte), (bi < eq.size()) ? 32'(eq[bi]) : 32'hEE);
                bi++;
            end
            hold_prev = b_bv && !b_br;
            prev_byte = b_byte;
            if (b_done) done_seen = 1'b1;
            @(negedge clk);
            if (abort_at >= 0 && ci == abort_at) break;
        end
        b_start = 1'b0; b_cv = 1'b0; b_br = 1'b0;
        if (abort_at >= 0) begin
            chk({tag, "/reached_abort"}, 32'(ci), 32'(abort_at));
            chk({tag, "/no_done"}, 32'(done_seen), 32'd0);
        end else begin
            chk({tag, "/done"}, 32'(done_seen), 32'd1);
            chk({tag, "/nbytes"}, 32'(bi), 32'(eq.size()));
            chk({tag, "/hold_viol"}, 32'(viol), 32'd0);
            chk({tag, "/excl_viol"}, 32'(excl), 32'd0);
            if (mode == 0) chk({tag, "/stall_done"}, 32'(stall), 32'hFFFF_FFFE);
            chk({tag, "/idle_after"}, {30'd0, b_busy, b_done}, 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        rst_n = 1'b0;
        s_start = 0; s_d = 0; s_cv = 0; s_coeff = 0; s_br = 0;
        b_start = 0; b_d = 0; b_cv = 0; b_coeff = 0; b_br = 0;
        repeat (3) @(negedge clk);
        chk("rst/small_outs", {s_cr, s_bv, s_busy, s_done, s_byte}, 32'd0);
        chk("rst/big_outs", {b_cr, b_bv, b_busy, b_done, b_byte}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle/big_outs", {b_cr, b_bv, b_busy, b_done, b_byte}, 32'd0);

        cq = '{16'h0001, 16'h0002, 16'h0000};
        eq = '{8'h01, 8'h20, 8'h00, 8'h00, 8'h00};
        run_small(4'd12, "t1_d12");

        cq = '{16'hFFFF, 16'h0000, 16'h0000};
        eq = '{8'h00, 8'h0D, 8'h00, 8'h00, 8'h00};
        run_small(4'd12, "t2_neg");

        cq = '{16'h000A, 16'h000B, 16'h000C};
        eq = '{8'hBA, 8'h0C};
        run_small(4'd4, "t3_d4");

        cq = '{16'h0001, 16'h0002, 16'h0000};
        eq = '{8'h01, 8'h20, 8'h00, 8'h00, 8'h00};
        run_small(4'd0, "t3_d0");

        cq = '{16'h0123, 16'h0456, 16'h0789};
        eq = '{8'h23, 8'h61, 8'h45, 8'h89, 8'h07};
        run_small(4'd15, "t3_d15");

        cq = '{16'h0003, 16'hFFFF, 16'h0001};
        eq = '{8'h05};
        run_small(4'd1, "t3_d1");

        run_big(4'd12, 12, 0, -1, "t4_d12");
        run_big(4'd10, 10, 1, -1, "t5_d10");
        run_big(4'd4, 4, 1, -1, "t5_d4");

        run_big(4'd12, 12, 0, 100, "t6_abort");
        chk("t6/busy_before_rst", 32'(b_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6/outs_in_rst", {b_cr, b_bv, b_busy, b_done, b_byte}, 32'd0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (b_done) dones++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (b_done) dones++;
        end
        chk("t6/no_done_after_rst", 32'(dones), 32'd0);
        chk("t6/idle_after_rst", {b_cr, b_bv, b_busy, b_done, b_byte}, 32'd0);
        run_big(4'd12, 12, 0, -1, "t6_rerun");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
